// File: rtl/xrv_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t  : LSU control states (IDLE, REQ, DONE)
//   F3_*         : funct3 access size / sign encodings
//   LS_ERR_*     : completion status codes reported on ls_err
//   f3_size      : funct3 -> access size (undefined codes behave as word)
//   f3_unsigned  : funct3 -> zero-extend flag for loads
//   f3_misaligned: access size vs. low address bits alignment check
package xrv_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ls_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] LS_ERR_OK       = 2'b00;
  localparam logic [1:0] LS_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LS_ERR_TIMEOUT  = 2'b10;

  // 011, 110 and 111 fall through to word size.
  function automatic ls_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering and load extension for the LSU (purely combinational).
//   funct3     in  : access size / sign
//   ea_lo      in  : effective address bits [1:0]
//   store_data in  : raw store operand (rs2)
//   rdata      in  : raw bus read word
//   be         out : byte-lane enables
//   wdata      out : store data replicated across lanes
//   load_data  out : selected lane, sign/zero extended
module lsu_align
  import xrv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  ls_size_t    size;
  logic        uns;
  logic [31:0] shifted;

  always_comb begin
    size    = f3_size(funct3);
    uns     = f3_unsigned(funct3);
    // Bring the addressed lane down to bit 0.
    shifted = rdata >> {ea_lo, 3'b000};
    be        = 4'hF;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << ea_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << ea_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'hF;
        wdata     = store_data;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one decoded load/store in IDLE, issues a single
// data-bus request held until acknowledged or timed out, then reports a
// one-cycle completion with status and load write-back.
//   clk, rst                      : clock, synchronous active-high reset
//   ex_valid, op_load, op_store   : decoded instruction handshake
//   funct3, dest                  : access size/sign, load destination
//   rs1_data, rs2_data, imm_signed: base, store data, signed offset
//   d_req/d_we/d_addr/d_be/d_wdata: data-bus request
//   d_ack, d_rdata                : data-bus response
//   ls_done, ls_err               : completion pulse and status
//   wb_en, wb_dest, wb_data       : load write-back (with ls_done)
module lsu
  import xrv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [4:0]  dest,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm_signed,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        ls_done,
  output logic        wb_en,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [1:0]  ls_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  state;
  logic [31:0] ea_q;
  logic [31:0] rs2_q;
  logic [2:0]  f3_q;
  logic [4:0]  dest_q;
  logic        load_q;
  logic [1:0]  err_q;
  logic [31:0] wb_data_q;
  logic [CW-1:0] cnt;

  logic [31:0] ea_next;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign ea_next = rs1_data + imm_signed;

  lsu_align u_align (
    .funct3     (f3_q),
    .ea_lo      (ea_q[1:0]),
    .store_data (rs2_q),
    .rdata      (d_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LSU_IDLE;
      cnt       <= '0;
      ea_q      <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      dest_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= LS_ERR_OK;
      wb_data_q <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (ex_valid && (op_load || op_store)) begin
            ea_q      <= ea_next;
            rs2_q     <= rs2_data;
            f3_q      <= funct3;
            dest_q    <= dest;
            load_q    <= op_load;
            cnt       <= '0;
            wb_data_q <= '0;
            if (f3_misaligned(funct3, ea_next[1:0])) begin
              err_q <= LS_ERR_MISALIGN;
              state <= LSU_DONE;
            end else begin
              err_q <= LS_ERR_OK;
              state <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          // Ack takes priority over the final timeout cycle.
          if (d_ack) begin
            if (load_q) wb_data_q <= al_load;
            state <= LSU_DONE;
          end else if (cnt == CNT_LAST) begin
            err_q <= LS_ERR_TIMEOUT;
            state <= LSU_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  assign d_req   = (state == LSU_REQ);
  assign d_we    = d_req && !load_q;
  assign d_be    = d_req ? al_be : 4'h0;
  assign d_addr  = {ea_q[31:2], 2'b00};
  assign d_wdata = al_wdata;

  assign ls_done = (state == LSU_DONE);
  assign ls_err  = err_q;
  assign wb_en   = ls_done && load_q && (err_q == LS_ERR_OK);
  assign wb_dest = dest_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, op_load, op_store;
  logic [2:0]  funct3;
  logic [4:0]  dest;
  logic [31:0] rs1_data, rs2_data, imm_signed;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        ls_done, wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  ls_err;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .op_load(op_load), .op_store(op_store),
    .funct3(funct3), .dest(dest), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_signed(imm_signed), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .ls_done(ls_done),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .ls_err(ls_err)
  );

  typedef struct {
    logic [1:0]  err;
    logic        wb_en;
    logic [4:0]  dest;
    logic [31:0] wb;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } req_t;

  done_t done_q[$];
  req_t  req_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Completion monitor: every ls_done must match the oldest expectation.
  done_t e;
  always @(negedge clk) begin
    if (ls_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ls_done: got ls_done=1 expected 0");
      end else begin
        e = done_q.pop_front();
        chk("ls_err", {30'h0, ls_err}, {30'h0, e.err});
        chk("wb_en", {31'h0, wb_en}, {31'h0, e.wb_en});
        chk("wb_dest", {27'h0, wb_dest}, {27'h0, e.dest});
        if (e.wb_en) chk("wb_data", wb_data, e.wb);
      end
    end
  end

  // Bus monitor: first request cycle is checked against the expectation,
  // later cycles must hold the request fields unchanged.
  req_t  r;
  logic  prev_req = 1'b0;
  logic  unstable;
  logic [68:0] held;
  always @(negedge clk) begin
    if (d_req === 1'b1 && !prev_req) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_d_req: got d_req=1 expected 0");
      end else begin
        r = req_q.pop_front();
        chk("d_addr", d_addr, r.addr);
        chk("d_be", {28'h0, d_be}, {28'h0, r.be});
        chk("d_we", {31'h0, d_we}, {31'h0, r.we});
        if (r.we) chk("d_wdata", d_wdata, r.wd);
      end
      held = {d_addr, d_be, d_we, d_wdata};
      unstable = 1'b0;
    end else if (d_req === 1'b1 && prev_req) begin
      if ({d_addr, d_be, d_we, d_wdata} !== held) unstable = 1'b1;
    end else if (d_req !== 1'b1 && prev_req) begin
      chk("bus_stable", {31'h0, unstable}, 32'h0);
    end
    prev_req = (d_req === 1'b1);
  end

  task automatic run(
    input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] dst,
    input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
    input int ack_at, input logic [31:0] rdata,
    input logic [31:0] x_addr, input logic [3:0] x_be, input logic [31:0] x_wd,
    input logic [1:0] x_err, input logic [31:0] x_wb, input int x_reqs, input int x_lat);
    int lat, reqs;
    bit seen;
    done_t de;
    req_t  re;
    @(negedge clk);
    ex_valid = 1'b1; op_load = ld; op_store = st; funct3 = f3; dest = dst;
    rs1_data = rs1; imm_signed = imm; rs2_data = rs2;
    de.err = x_err; de.wb_en = ld && (x_err == 2'b00); de.dest = dst; de.wb = x_wb;
    done_q.push_back(de);
    if (x_reqs > 0) begin
      re.addr = x_addr; re.be = x_be; re.we = st; re.wd = x_wd;
      req_q.push_back(re);
    end
    lat = 0; reqs = 0; seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ex_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
      end
      d_ack = 1'b0;
      if (d_req === 1'b1) begin
        reqs++;
        if (reqs == ack_at) begin
          d_ack = 1'b1;
          d_rdata = rdata;
        end
      end
      if (ls_done === 1'b1) begin
        seen = 1;
        lat = c + 1;  // issue cycle through ls_done cycle, inclusive
      end
    end
    d_ack = 1'b0;
    if (!seen) begin
      n_total++;
      $display("FAIL done_wait: got no ls_done within 40 cycles expected ls_done");
    end
    chk("latency", lat, x_lat);
    chk("req_cycles", reqs, x_reqs);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; funct3 = '0;
    dest = '0; rs1_data = '0; rs2_data = '0; imm_signed = '0; d_ack = 1'b0; d_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_req", {31'h0, d_req}, 32'h0);
    chk("rst_d_be", {28'h0, d_be}, 32'h0);
    chk("rst_d_addr", d_addr, 32'h0);
    chk("rst_d_wdata", d_wdata, 32'h0);
    chk("rst_ls_done", {31'h0, ls_done}, 32'h0);
    chk("rst_ls_err", {30'h0, ls_err}, 32'h0);
    chk("rst_wb", {wb_en, wb_dest, wb_data[25:0]}, 32'h0);
    rst = 1'b0;

    //  ld st f3      dst rs1           imm           rs2           ack rdata        addr          be    wdata         err    wb            reqs lat
    run(0, 1, 3'b010, 1,  32'h100,      32'h4,        32'hDEADBEEF, 1,  32'h0,       32'h104,      4'hF, 32'hDEADBEEF, 2'b00, 32'h0,        1,  3);
    run(1, 0, 3'b000, 5,  32'h200,      32'h3,        32'h0,        2,  32'h80123456, 32'h200,     4'h8, 32'h0,        2'b00, 32'hFFFFFF80, 2,  4);
    run(1, 0, 3'b100, 6,  32'h200,      32'h3,        32'h0,        1,  32'h80123456, 32'h200,     4'h8, 32'h0,        2'b00, 32'h00000080, 1,  3);
    run(0, 1, 3'b001, 2,  32'h100,      32'h2,        32'h00001234, 1,  32'h0,       32'h100,      4'hC, 32'h12341234, 2'b00, 32'h0,        1,  3);
    run(1, 0, 3'b001, 7,  32'h100,      32'h1,        32'h0,        1,  32'h0,       32'h0,        4'h0, 32'h0,        2'b01, 32'h0,        0,  2);
    run(1, 0, 3'b010, 8,  32'h300,      32'h0,        32'h0,        0,  32'h0,       32'h300,      4'hF, 32'h0,        2'b10, 32'h0,        16, 18);
    run(1, 0, 3'b010, 9,  32'h304,      32'h0,        32'h0,        16, 32'hCAFEF00D, 32'h304,     4'hF, 32'h0,        2'b00, 32'hCAFEF00D, 16, 18);
    run(1, 0, 3'b001, 10, 32'h200,      32'h6,        32'h0,        1,  32'h80017FFF, 32'h204,     4'hC, 32'h0,        2'b00, 32'hFFFF8001, 1,  3);
    run(1, 0, 3'b101, 11, 32'h200,      32'h0,        32'h0,        3,  32'h12349ABC, 32'h200,     4'h3, 32'h0,        2'b00, 32'h00009ABC, 3,  5);
    run(0, 1, 3'b000, 12, 32'h100,      32'h1,        32'h123456AB, 1,  32'h0,       32'h100,      4'h2, 32'hABABABAB, 2'b00, 32'h0,        1,  3);
    run(0, 1, 3'b000, 17, 32'h100,      32'h3,        32'h00000077, 1,  32'h0,       32'h100,      4'h8, 32'h77777777, 2'b00, 32'h0,        1,  3);
    run(1, 0, 3'b010, 13, 32'h1000,     32'hFFFFFFFC, 32'h0,        1,  32'h11223344, 32'hFFC,     4'hF, 32'h0,        2'b00, 32'h11223344, 1,  3);
    run(1, 0, 3'b011, 14, 32'h10,       32'h0,        32'h0,        1,  32'hA5A55A5A, 32'h10,      4'hF, 32'h0,        2'b00, 32'hA5A55A5A, 1,  3);
    run(1, 0, 3'b111, 15, 32'h10,       32'h2,        32'h0,        1,  32'h0,       32'h0,        4'h0, 32'h0,        2'b01, 32'h0,        0,  2);
    run(0, 1, 3'b010, 16, 32'h100,      32'h2,        32'h0,        1,  32'h0,       32'h0,        4'h0, 32'h0,        2'b01, 32'h0,        0,  2);

    // ex_valid without an op, and a stray ack, while idle.
    @(negedge clk);
    ex_valid = 1'b1; d_ack = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; d_ack = 1'b0;
    chk("idle_noop_req", {31'h0, d_req}, 32'h0);
    chk("idle_noop_done", {31'h0, ls_done}, 32'h0);
    @(negedge clk);
    chk("idle_noop_req2", {31'h0, d_req}, 32'h0);

    // Reset in the third request cycle with extra ex_valid pulses while busy.
    begin
      req_t re;
      @(negedge clk);
      ex_valid = 1'b1; op_load = 1'b1; funct3 = 3'b010; dest = 3;
      rs1_data = 32'h400; imm_signed = 32'h0;
      re.addr = 32'h400; re.be = 4'hF; re.we = 1'b0; re.wd = 32'h0;
      req_q.push_back(re);
      @(negedge clk);
      op_load = 1'b0; op_store = 1'b1; rs1_data = 32'h800; rs2_data = 32'h55;
      @(negedge clk);
      chk("busy_ignores_ex", d_addr, 32'h400);
      @(negedge clk);
      chk("rst_req3_d_req", {31'h0, d_req}, 32'h1);
      chk("rst_req3_d_we", {31'h0, d_we}, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_abort_d_req", {31'h0, d_req}, 32'h0);
      chk("rst_abort_done", {31'h0, ls_done}, 32'h0);
      chk("rst_abort_addr", d_addr, 32'h0);
      chk("rst_abort_be", {28'h0, d_be}, 32'h0);
      rst = 1'b0; ex_valid = 1'b0; op_store = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {31'h0, d_req}, 32'h0);
    end

    run(1, 0, 3'b010, 20, 32'h500, 32'h8, 32'h0, 2, 32'h0BADF00D, 32'h508, 4'hF, 32'h0, 2'b00, 32'h0BADF00D, 2, 4);

    repeat (3) @(negedge clk);
    chk("done_q_drained", done_q.size(), 32'h0);
    chk("req_q_drained", req_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
